// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl_if
// Description : Bundle of every signal between the instruction fetch
//               controller and its environment: the start strobe, the
//               byte-wide instruction memory port, the issue handshake with
//               the redirect inputs, and the sticky status flags.
//               master : the fetch controller side
//               slave  : the environment (memory, decoder, control) side
//   start          begin fetching at the current PC (only seen in IDLE)
//   mem_req        byte read request
//   mem_addr       byte address of the current request
//   mem_ack        request accepted; mem_rdata valid in the same cycle
//   mem_rdata      returned instruction byte
//   instr          assembled instruction, byte 0 in instr[0:7]
//   pc_out         address of the instruction on instr
//   instr_valid    instr / pc_out valid
//   instr_ready    downstream accepts instr
//   pc_load        take pc_in as the next PC on the issue handshake
//   pc_in          redirect target
//   halted, mem_error, invalid_instr  sticky status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_ctrl_if;
  logic        start;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [0:79] instr;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic [63:0] pc_in;
  logic        halted;
  logic        mem_error;
  logic        invalid_instr;

  modport master (
    input  start, mem_ack, mem_rdata, instr_ready, pc_load, pc_in,
    output mem_req, mem_addr, instr, pc_out, instr_valid,
           halted, mem_error, invalid_instr
  );

  modport slave (
    output start, mem_ack, mem_rdata, instr_ready, pc_load, pc_in,
    input  mem_req, mem_addr, instr, pc_out, instr_valid,
           halted, mem_error, invalid_instr
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Byte-serial instruction fetch controller. Reads one byte per
//               memory ack starting at the PC, decodes the instruction length
//               from the icode in byte 0, assembles up to 10 bytes, presents
//               the instruction with a valid/ready handshake and advances the
//               PC (sequentially or via pc_load redirect). Halt, invalid
//               icode and out-of-range addresses end in a terminal STOP state.
// Parameters  : IMEM_SIZE - instruction memory size in bytes
//               RESET_PC  - PC loaded at reset
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - instr_fetch_ctrl_if.master (start, memory port,
//                       issue handshake, redirect, status flags)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter int          IMEM_SIZE = 256,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  instr_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [63:0] pc, pc_nx;
  logic [3:0]  count, count_nx;
  logic [0:79] instr, instr_nx;
  logic [63:0] pc_out, pc_out_nx;
  logic        halted, halted_nx;
  logic        mem_error, mem_error_nx;
  logic        invalid_instr, invalid_instr_nx;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        instr_valid;

  logic [63:0] fetch_addr;
  logic        addr_ok;
  logic [3:0]  cur_icode;
  logic [3:0]  cur_len;

  // Instruction length in bytes from the icode; 0 marks an invalid icode.
  function automatic logic [3:0] decode_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:       decode_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: decode_len = 4'd2;
      4'h3, 4'h4, 4'h5:       decode_len = 4'd10;
      4'h7, 4'h8:             decode_len = 4'd9;
      default:                decode_len = 4'd0;
    endcase
  endfunction

  assign fetch_addr = pc + {60'd0, count};
  assign addr_ok    = (fetch_addr < 64'(IMEM_SIZE));

  // While byte 0 is on the bus it has not been captured yet, so the length
  // is decoded straight from mem_rdata; afterwards from the stored byte.
  assign cur_icode = (count == 4'd0) ? bus.mem_rdata[7:4] : instr[0:3];
  assign cur_len   = decode_len(cur_icode);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      count         <= 4'd0;
      instr         <= '0;
      pc_out        <= 64'd0;
      halted        <= 1'b0;
      mem_error     <= 1'b0;
      invalid_instr <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      count         <= count_nx;
      instr         <= instr_nx;
      pc_out        <= pc_out_nx;
      halted        <= halted_nx;
      mem_error     <= mem_error_nx;
      invalid_instr <= invalid_instr_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx         = state;
    pc_nx            = pc;
    count_nx         = count;
    instr_nx         = instr;
    pc_out_nx        = pc_out;
    halted_nx        = halted;
    mem_error_nx     = mem_error;
    invalid_instr_nx = invalid_instr;
    mem_req          = 1'b0;
    mem_addr         = 64'd0;
    instr_valid      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = FETCH;
          count_nx = 4'd0;
          instr_nx = '0;
        end
      end

      FETCH: begin
        mem_addr = fetch_addr;
        if (!addr_ok) begin
          // Out-of-range byte: the request is suppressed, not issued.
          mem_error_nx = 1'b1;
          state_nx     = STOP;
        end else begin
          mem_req = 1'b1;
          if (bus.mem_ack) begin
            instr_nx[{count, 3'b000} +: 8] = bus.mem_rdata;
            count_nx = count + 4'd1;
            if (cur_len == 4'd0) begin
              // Only reachable on byte 0; the icode itself is unusable.
              invalid_instr_nx = 1'b1;
              state_nx         = STOP;
            end else if ((count + 4'd1) == cur_len) begin
              pc_out_nx = pc;
              state_nx  = ISSUE;
            end
          end
        end
      end

      ISSUE: begin
        instr_valid = 1'b1;
        if (bus.instr_ready) begin
          if (instr[0:3] == 4'h0) begin
            halted_nx = 1'b1;
            state_nx  = STOP;
          end else begin
            // count equals the instruction length while in ISSUE.
            pc_nx    = bus.pc_load ? bus.pc_in : (pc + {60'd0, count});
            count_nx = 4'd0;
            instr_nx = '0;
            state_nx = FETCH;
          end
        end
      end

      STOP: begin
        state_nx = STOP;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.mem_req       = mem_req;
  assign bus.mem_addr      = mem_addr;
  assign bus.instr_valid   = instr_valid;
  assign bus.instr         = instr;
  assign bus.pc_out        = pc_out;
  assign bus.halted        = halted;
  assign bus.mem_error     = mem_error;
  assign bus.invalid_instr = invalid_instr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Self-checking bench for instr_fetch_ctrl. A byte array acts
//               as instruction memory; expected requests, assembled
//               instructions and final status are computed from the icode
//               length table and the memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;
  localparam int          IMEM_SIZE = 256;
  localparam logic [63:0] RESET_PC  = 64'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(
    .IMEM_SIZE (IMEM_SIZE),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  typedef enum int {OUT_ISSUE, OUT_INVALID, OUT_MEMERR} outcome_t;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 10;
      4'h7, 4'h8:             return 9;
      default:                return 0;
    endcase
  endfunction

  task automatic clear_in();
    bus.start = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    bus.instr_ready = 1'b0; bus.pc_load = 1'b0; bus.pc_in = 64'd0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_req"},   80'(bus.mem_req),       80'd0);
    check({tag, "_mem_addr"},  80'(bus.mem_addr),      80'd0);
    check({tag, "_instr"},     80'(bus.instr),         80'd0);
    check({tag, "_pc_out"},    80'(bus.pc_out),        80'd0);
    check({tag, "_valid"},     80'(bus.instr_valid),   80'd0);
    check({tag, "_halted"},    80'(bus.halted),        80'd0);
    check({tag, "_mem_error"}, 80'(bus.mem_error),     80'd0);
    check({tag, "_invalid"},   80'(bus.invalid_instr), 80'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Terminal state: inputs that would normally act must be ignored.
  task automatic stop_check(input string tag, input bit h, input bit me, input bit ii);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_stop_req"},   80'(bus.mem_req),     80'd0);
      check({tag, "_stop_valid"}, 80'(bus.instr_valid), 80'd0);
      bus.start = 1'b1; bus.mem_ack = 1'b1; bus.pc_load = 1'b1;
      bus.instr_ready = 1'b1; bus.pc_in = 64'd0;
    end
    @(negedge clk);
    clear_in();
    check({tag, "_halted"},    80'(bus.halted),        80'(h));
    check({tag, "_mem_error"}, 80'(bus.mem_error),     80'(me));
    check({tag, "_invalid"},   80'(bus.invalid_instr), 80'(ii));
  endtask

  // Runs one instruction starting in its first FETCH cycle, serving memory
  // with ack_wait idle cycles per byte and accepting after rdy_wait cycles.
  task automatic run_instr(input logic [63:0] pc, input int ack_wait, input int rdy_wait,
                           input bit load, input logic [63:0] target,
                           output logic [79:0] got_instr, output bit stopped);
    outcome_t    oc;
    int          len, exp_reqs, nreq, w, r;
    logic [3:0]  ic;
    logic [79:0] exp_instr;
    bit          done, last_ack;

    exp_instr = '0; ic = 4'h0; len = 0;
    if (pc >= 64'(IMEM_SIZE)) begin
      oc = OUT_MEMERR; exp_reqs = 0;
    end else begin
      ic  = mem[pc[7:0]][7:4];
      len = model_len(ic);
      if (len == 0) begin
        oc = OUT_INVALID; exp_reqs = 1;
      end else if (pc + 64'(len) > 64'(IMEM_SIZE)) begin
        oc = OUT_MEMERR; exp_reqs = IMEM_SIZE - int'(pc[31:0]);
      end else begin
        oc = OUT_ISSUE; exp_reqs = len;
        for (int k = 0; k < len; k++) exp_instr[79 - 8*k -: 8] = mem[pc[7:0] + 8'(k)];
      end
    end

    nreq = 0; w = 0; r = 0; done = 1'b0; last_ack = 1'b0; stopped = 1'b0; got_instr = '0;
    for (int cyc = 0; cyc < 150 && !done; cyc++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0; bus.instr_ready = 1'b0; bus.pc_load = 1'b0;
      bus.mem_rdata = 8'($urandom); bus.pc_in = {$urandom, $urandom};
      if (cyc == 0) check("req_latency", 80'(bus.mem_req), 80'(exp_reqs > 0));
      if (last_ack) begin
        check("valid_latency", 80'(bus.instr_valid), 80'd1);
        last_ack = 1'b0;
      end
      if (bus.mem_req) begin
        if (nreq >= exp_reqs) begin
          check("request_count", 80'(nreq + 1), 80'(exp_reqs));
          done = 1'b1;
        end else begin
          check("mem_addr", 80'(bus.mem_addr), 80'(pc + 64'(nreq)));
          if (w < ack_wait) begin
            w++;
          end else begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[7:0]];
            w = 0;
            nreq++;
            if (nreq == exp_reqs && oc == OUT_ISSUE) last_ack = 1'b1;
          end
        end
      end else if (bus.instr_valid) begin
        if (oc != OUT_ISSUE) begin
          check("unexpected_valid", 80'(bus.instr_valid), 80'd0);
          done = 1'b1;
        end else begin
          check("instr",  80'(bus.instr),  exp_instr);
          check("pc_out", 80'(bus.pc_out), 80'(pc));
          got_instr = 80'(bus.instr);
          // Stray acks and un-handshaked redirects must not disturb the issue.
          bus.mem_ack = 1'($urandom_range(0, 1));
          if (r < rdy_wait) begin
            r++;
            bus.pc_load = 1'b1;
          end else begin
            bus.instr_ready = 1'b1;
            bus.pc_load = load;
            if (load) bus.pc_in = target;
            done = 1'b1;
          end
        end
      end else if (nreq == exp_reqs && oc == OUT_INVALID && bus.invalid_instr) begin
        check("invalid_flag",   80'(bus.invalid_instr), 80'd1);
        check("invalid_no_err", 80'(bus.mem_error),     80'd0);
        done = 1'b1; stopped = 1'b1;
      end else if (nreq == exp_reqs && oc == OUT_MEMERR && bus.mem_error) begin
        check("memerr_flag",    80'(bus.mem_error),     80'd1);
        check("memerr_no_inv",  80'(bus.invalid_instr), 80'd0);
        done = 1'b1; stopped = 1'b1;
      end
    end
    if (!done) check("timeout", 80'd0, 80'd1);
    if (done && oc == OUT_ISSUE && ic == 4'h0) begin
      @(negedge clk);
      clear_in();
      check("halt_flag",  80'(bus.halted),      80'd1);
      check("halt_req",   80'(bus.mem_req),     80'd0);
      check("halt_valid", 80'(bus.instr_valid), 80'd0);
      stopped = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] got;
    bit          stopped, ld;
    logic [63:0] pc, tgt, a, halt_addr;
    logic [3:0]  ic;
    int          len, n;
    logic [63:0] starts [$];
    logic [3:0]  valid_ic [11];

    valid_ic = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    clear_in();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Power-on reset: outputs must follow rst_n without any clock edge.
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_req", 80'(bus.mem_req), 80'd0);
    end

    // irmovq at 0, jump at 10 redirected to 0x20, then a random program.
    mem[0] = 8'h30; mem[1] = 8'hF4; mem[2] = 8'h0A;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    mem[10] = 8'h70; mem[11] = 8'h20;
    for (int i = 12; i < 19; i++) mem[i] = 8'h00;
    a = 64'h20;
    for (int i = 0; i < 12; i++) begin
      ic  = valid_ic[$urandom_range(0, 10)];
      len = model_len(ic);
      mem[a[7:0]] = {ic, 4'($urandom)};
      for (int k = 1; k < len; k++) mem[a[7:0] + 8'(k)] = 8'($urandom);
      starts.push_back(a);
      a = a + 64'(len);
    end
    halt_addr = a;
    mem[halt_addr[7:0]] = {4'h0, 4'($urandom)};

    do_start();
    run_instr(64'd0, 0, 0, 1'b0, 64'd0, got, stopped);
    check("irmovq_const", got, 80'h30F40A00000000000000);
    run_instr(64'd10, 0, 1, 1'b1, 64'h20, got, stopped);
    pc = 64'h20; n = 0; stopped = 1'b0;
    while (!stopped && n < 40) begin
      len = model_len(mem[pc[7:0]][7:4]);
      if (n >= 20) begin
        ld = 1'b1; tgt = halt_addr;
      end else if ($urandom_range(0, 3) == 0) begin
        ld = 1'b1; tgt = starts[$urandom_range(0, starts.size() - 1)];
      end else begin
        ld = 1'b0; tgt = pc + 64'(len);
      end
      run_instr(pc, $urandom_range(0, 2), $urandom_range(0, 2), ld, tgt, got, stopped);
      pc = tgt;
      n++;
    end
    check("prog_halted", 80'(stopped), 80'd1);
    stop_check("prog", 1'b1, 1'b0, 1'b0);

    // nop then halt with downstream always ready.
    do_reset();
    mem[0] = 8'h10; mem[1] = 8'h00;
    do_start();
    run_instr(64'd0, 0, 0, 1'b0, 64'd0, got, stopped);
    run_instr(64'd1, 0, 0, 1'b0, 64'd0, got, stopped);
    stop_check("halt", 1'b1, 1'b0, 1'b0);

    // Invalid icode F, then a random invalid icode.
    do_reset();
    mem[0] = 8'hF0;
    do_start();
    run_instr(64'd0, 0, 0, 1'b0, 64'd0, got, stopped);
    stop_check("inv_f0", 1'b0, 1'b0, 1'b1);
    do_reset();
    mem[0] = {4'($urandom_range(12, 15)), 4'($urandom)};
    do_start();
    run_instr(64'd0, 1, 0, 1'b0, 64'd0, got, stopped);
    stop_check("inv_rand", 1'b0, 1'b0, 1'b1);

    // 10-byte instruction at 254 runs off the end of memory.
    do_reset();
    mem[0] = 8'h70;
    mem[254] = 8'h30; mem[255] = 8'hF4;
    do_start();
    run_instr(64'd0, 0, 0, 1'b1, 64'd254, got, stopped);
    run_instr(64'd254, 1, 0, 1'b0, 64'd0, got, stopped);
    stop_check("edge254", 1'b0, 1'b1, 1'b0);

    // Redirect to the first out-of-range address: no request at all.
    do_reset();
    do_start();
    run_instr(64'd0, 0, 0, 1'b1, 64'd256, got, stopped);
    run_instr(64'd256, 0, 0, 1'b0, 64'd0, got, stopped);
    stop_check("edge256", 1'b0, 1'b1, 1'b0);

    // Reset during the second byte wait of a slow fetch.
    do_reset();
    mem[0] = 8'h30; mem[1] = 8'hF4; mem[2] = 8'h0A;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    mem[10] = 8'h10;
    do_start();
    @(negedge clk); clear_in();
    check("slow_b0_addr", 80'(bus.mem_addr), 80'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = mem[0];
    @(negedge clk); bus.mem_ack = 1'b0;
    check("slow_b1_addr", 80'(bus.mem_addr), 80'd1);
    @(negedge clk);
    check("slow_b1_req", 80'(bus.mem_req), 80'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_fetch");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check_reset("rst_fetch_rel");
    @(negedge clk); check("rst_wait_start", 80'(bus.mem_req), 80'd0);
    do_start();
    run_instr(RESET_PC, 3, 0, 1'b0, 64'd0, got, stopped);

    // Reset while the following nop is being offered.
    @(negedge clk);
    check("issue_rst_addr", 80'(bus.mem_addr), 80'd10);
    check("issue_rst_req",  80'(bus.mem_req),  80'd1);
    bus.instr_ready = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = mem[10];
    @(negedge clk); bus.mem_ack = 1'b0;
    check("issue_rst_valid", 80'(bus.instr_valid), 80'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_issue");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check_reset("rst_issue_rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
